// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline latch family: state encoding and default geometry.
package pipe_pkg;

  typedef enum logic [1:0] {
    PL_EMPTY = 2'd0,
    PL_ONE   = 2'd1,
    PL_TWO   = 2'd2
  } pl_state_e;

  localparam int PL_WIDTH      = 32;
  localparam int PL_NUM_FIELDS = 4;
  localparam int PL_NUM_FLAGS  = 1;
  localparam int PL_CNT_W      = 16;

endpackage

// File: rtl/pipe_latch_hs_if.sv
// Upstream and downstream valid/ready channels of one pipeline latch.
// The master side drives entries in and consumes entries out; the latch is the slave.
interface pipe_latch_hs_if
  import pipe_pkg::*;
#(
  parameter int WIDTH      = PL_WIDTH,
  parameter int NUM_FIELDS = PL_NUM_FIELDS,
  parameter int NUM_FLAGS  = PL_NUM_FLAGS
);
  logic                        in_valid;
  logic                        in_ready;
  logic [NUM_FIELDS*WIDTH-1:0] in_data;
  logic [NUM_FLAGS-1:0]        in_flag;
  logic                        out_valid;
  logic                        out_ready;
  logic [NUM_FIELDS*WIDTH-1:0] out_data;
  logic [NUM_FLAGS-1:0]        out_flag;

  modport master (
    output in_valid, in_data, in_flag, out_ready,
    input  in_ready, out_valid, out_data, out_flag
  );

  modport slave (
    input  in_valid, in_data, in_flag, out_ready,
    output in_ready, out_valid, out_data, out_flag
  );
endinterface

// File: rtl/pipe_slot.sv
// One latch entry register (data fields + flags) with load enable and synchronous reset.
module pipe_slot #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clock) begin
    if (reset)     q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/pipe_latch_hs.sv
// Inter-stage pipeline latch: main + skid slot, valid/ready handshake, registered in_ready, flush.
// Optional stall/bubble counters are built when PIPE_LATCH_STATS_EN is defined.
module pipe_latch_hs
  import pipe_pkg::*;
#(
  parameter int WIDTH      = PL_WIDTH,
  parameter int NUM_FIELDS = PL_NUM_FIELDS,
  parameter int NUM_FLAGS  = PL_NUM_FLAGS
`ifdef PIPE_LATCH_STATS_EN
  ,
  parameter int CNT_W      = PL_CNT_W
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  pipe_latch_hs_if.slave   bus
`ifdef PIPE_LATCH_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
`endif
);

  localparam int DW = NUM_FIELDS * WIDTH;
  localparam int EW = DW + NUM_FLAGS;

  pl_state_e             state;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic                  in_fire;
  logic                  out_fire;
  logic [1:0]            slot_load;
  logic [1:0][EW-1:0]    slot_d;
  logic [1:0][EW-1:0]    slot_q;

  assign in_fire  = bus.in_valid & in_ready_q;
  assign out_fire = out_valid_q & bus.out_ready;

  // Slot 0 is main (drives the outputs), slot 1 is skid.
  always_comb begin
    slot_load = 2'b00;
    slot_d[0] = {bus.in_flag, bus.in_data};
    slot_d[1] = {bus.in_flag, bus.in_data};
    if (!flush) begin
      case (state)
        PL_EMPTY: slot_load[0] = in_fire;
        PL_ONE: begin
          slot_load[0] = in_fire & out_fire;
          slot_load[1] = in_fire & ~out_fire;
        end
        PL_TWO: begin
          slot_load[0] = out_fire;
          slot_d[0]    = slot_q[1];
        end
        default: slot_load = 2'b00;
      endcase
    end
  end

  for (genvar s = 0; s < 2; s++) begin : g_slot
    pipe_slot #(.W(EW)) u_slot (
      .clock (clock),
      .reset (reset),
      .load  (slot_load[s]),
      .d     (slot_d[s]),
      .q     (slot_q[s])
    );
  end

  // in_ready/out_valid are registered from the next state so neither depends on inputs.
  always_ff @(posedge clock) begin
    if (reset | flush) begin
      state       <= PL_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        PL_EMPTY:
          if (in_fire) begin
            state       <= PL_ONE;
            out_valid_q <= 1'b1;
          end
        PL_ONE:
          if (in_fire & ~out_fire) begin
            state      <= PL_TWO;
            in_ready_q <= 1'b0;
          end else if (~in_fire & out_fire) begin
            state       <= PL_EMPTY;
            out_valid_q <= 1'b0;
          end
        PL_TWO:
          if (out_fire) begin
            state      <= PL_ONE;
            in_ready_q <= 1'b1;
          end
        default: begin
          state       <= PL_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign {bus.out_flag, bus.out_data} = slot_q[0];

`ifdef PIPE_LATCH_STATS_EN
  // Saturating counters; flush deliberately leaves them alone.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid_q & ~bus.out_ready & ~&stall_cnt) stall_cnt <= stall_cnt + CNT_W'(1);
      if (~out_valid_q & ~&bubble_cnt)                bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_latch_hs.sv
// Self-checking bench for pipe_latch_hs: directed vector table, hand sequences, random vs FIFO model.
module tb_pipe_latch_hs;
  import pipe_pkg::*;

  localparam int WIDTH = 32;
  localparam int NF    = 4;
  localparam int NG    = 1;
  localparam int DW    = NF * WIDTH;
`ifdef PIPE_LATCH_STATS_EN
  localparam int CNT_W = 4;
  logic [CNT_W-1:0] stall_cnt, bubble_cnt;
`endif

  logic clock = 1'b0;
  logic reset, flush;
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  pipe_latch_hs_if #(.WIDTH(WIDTH), .NUM_FIELDS(NF), .NUM_FLAGS(NG)) bus ();

  pipe_latch_hs #(
    .WIDTH(WIDTH), .NUM_FIELDS(NF), .NUM_FLAGS(NG)
`ifdef PIPE_LATCH_STATS_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
`ifdef PIPE_LATCH_STATS_EN
    , .stall_cnt  (stall_cnt)
    , .bubble_cnt (bubble_cnt)
`endif
  );

  typedef struct {
    logic        rst, fl, iv;
    logic [31:0] d;
    logic        ordy;
    logic        ev, er, cd;
    logic [31:0] ed;
  } vec_t;

  vec_t tbl[14];
  logic [DW:0] q[$];

  function automatic logic [DW-1:0] mk(input logic [31:0] d);
    return {d * 32'd7, d * 32'd5, d * 32'd3, d};
  endfunction

  function automatic logic [DW:0] ent(input logic [31:0] d);
    return {^d, mk(d)};
  endfunction

  function automatic vec_t mkv(input logic rst, fl, iv, input logic [31:0] d, input logic ordy,
                               input logic ev, er, cd, input logic [31:0] ed);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.ev = ev; v.er = er; v.cd = cd; v.ed = ed;
    return v;
  endfunction

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [DW:0] act, input logic [DW:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, f, iv, input logic [31:0] d, input logic ordy);
    reset         = r;
    flush         = f;
    bus.in_valid  = iv;
    bus.in_data   = mk(d);
    bus.in_flag   = ^d;
    bus.out_ready = ordy;
  endtask

  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    // A then B into a stalled latch, C refused while full, drain in order
    tbl[0]  = mkv(0, 0, 1, 32'h0A, 0,  1, 1, 1, 32'h0A);
    tbl[1]  = mkv(0, 0, 1, 32'h0B, 0,  1, 0, 1, 32'h0A);
    tbl[2]  = mkv(0, 0, 1, 32'h0C, 0,  1, 0, 1, 32'h0A);
    tbl[3]  = mkv(0, 0, 0, 32'h00, 1,  1, 1, 1, 32'h0B);
    tbl[4]  = mkv(0, 0, 0, 32'h00, 1,  0, 1, 0, 32'h00);
    // flush while full with a new entry presented
    tbl[5]  = mkv(0, 0, 1, 32'h21, 0,  1, 1, 1, 32'h21);
    tbl[6]  = mkv(0, 0, 1, 32'h22, 0,  1, 0, 1, 32'h21);
    tbl[7]  = mkv(0, 1, 1, 32'hC3, 0,  0, 1, 0, 32'h00);
    tbl[8]  = mkv(0, 0, 0, 32'h00, 1,  0, 1, 0, 32'h00);
    tbl[9]  = mkv(0, 0, 1, 32'h31, 1,  1, 1, 1, 32'h31);
    // reset while full clears outputs
    tbl[10] = mkv(0, 0, 1, 32'h32, 0,  1, 0, 1, 32'h31);
    tbl[11] = mkv(1, 0, 1, 32'h33, 0,  0, 1, 1, 32'h00);
    tbl[12] = mkv(0, 0, 1, 32'h41, 1,  1, 1, 1, 32'h41);
    tbl[13] = mkv(0, 0, 0, 32'h00, 1,  0, 1, 0, 32'h00);

    drive(1, 0, 0, 32'h0, 0);
    tick();
    tick();
    chk_i("reset_out_valid", int'(bus.out_valid), 0);
    chk_i("reset_in_ready",  int'(bus.in_ready), 1);
    chk_w("reset_out_entry", {bus.out_flag, bus.out_data}, '0);

    // sustained streaming: one entry per cycle, latency one
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 1, 32'h11 + i, 1);
      tick();
      chk_i($sformatf("stream%0d_valid", i), int'(bus.out_valid), 1);
      chk_i($sformatf("stream%0d_ready", i), int'(bus.in_ready), 1);
      chk_w($sformatf("stream%0d_data", i), {bus.out_flag, bus.out_data}, ent(32'h11 + i));
    end
    drive(0, 0, 0, 32'h0, 1);
    tick();
    chk_i("stream_drain_valid", int'(bus.out_valid), 0);

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      tick();
      chk_i($sformatf("vec%0d_valid", i), int'(bus.out_valid), int'(tbl[i].ev));
      chk_i($sformatf("vec%0d_ready", i), int'(bus.in_ready), int'(tbl[i].er));
      if (tbl[i].cd)
        chk_w($sformatf("vec%0d_data", i), {bus.out_flag, bus.out_data}, ent(tbl[i].ed));
    end

    // random traffic against a 2-deep FIFO model whose ready is "fewer than two held"
    drive(1, 0, 0, 32'h0, 0);
    tick();
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      logic          iv, ordy, fl, pop, push;
      logic [DW-1:0] d;
      logic [NG-1:0] fg;
      chk_i("rnd_valid", int'(bus.out_valid), int'(q.size() > 0));
      chk_i("rnd_ready", int'(bus.in_ready), int'(q.size() < 2));
      if (q.size() > 0) chk_w("rnd_data", {bus.out_flag, bus.out_data}, q[0]);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 1) != 0);
      fl   = ($urandom_range(0, 63) == 0);
      d    = {$urandom, $urandom, $urandom, $urandom};
      fg   = NG'($urandom_range(0, 1));
      reset = 1'b0;
      flush = fl;
      bus.in_valid = iv;
      bus.in_data  = d;
      bus.in_flag  = fg;
      bus.out_ready = ~ordy;
      #1;
      chk_i("rnd_ready_indep", int'(bus.in_ready), int'(q.size() < 2));
      bus.out_ready = ordy;
      pop  = (q.size() > 0) && ordy;
      push = iv && (q.size() < 2);
      tick();
      if (fl) q.delete();
      else begin
        if (pop)  void'(q.pop_front());
        if (push) q.push_back({fg, d});
      end
    end

`ifdef PIPE_LATCH_STATS_EN
    drive(1, 0, 0, 32'h0, 0);
    tick();
    drive(0, 0, 1, 32'h5, 0);
    chk_i("stats_reset_stall",  int'(stall_cnt), 0);
    chk_i("stats_reset_bubble", int'(bubble_cnt), 0);
    tick();
    chk_i("stats_bubble_one", int'(bubble_cnt), 1);
    drive(0, 0, 0, 32'h0, 0);
    repeat (20) tick();
    chk_i("stats_stall_sat", int'(stall_cnt), 15);
    drive(0, 1, 0, 32'h0, 0);
    tick();
    drive(0, 0, 0, 32'h0, 0);
    tick();
    chk_i("stats_stall_after_flush", int'(stall_cnt), 15);
    chk_i("stats_flush_valid", int'(bus.out_valid), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
